// File: rtl/unitate_fetch_pkg.sv
// rtl/unitate_fetch_pkg.sv - shared RISC-8 widths, halt word and fetch state type
package pachet_risc8;

   localparam int ADDR_W   = 8;
   localparam int INSTR_W  = 16;
   localparam int OPCODE_W = 4;

   localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } stare_fetch_t;

endpackage

// File: rtl/numarator_pc.sv
// rtl/numarator_pc.sv - program counter register with load, increment and hold
module numarator_pc #(
   parameter int            W         = 8,
   parameter logic [W-1:0]  RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic [W-1:0] value
);

   // load wins over increment; increment wraps naturally at 2^W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= RESET_VAL;
      end else if (load) begin
         value <= load_val;
      end else if (inc) begin
         value <= value + W'(1);
      end
   end

endmodule

// File: rtl/unitate_fetch.sv
// rtl/unitate_fetch.sv - RISC-8 fetch stage; halt-word detection under RISC8_FETCH_HALT_EN
module unitate_fetch #(
   parameter int                 ADDR_W   = pachet_risc8::ADDR_W,
   parameter int                 INSTR_W  = pachet_risc8::INSTR_W,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  address,
   input  logic [INSTR_W-1:0] instruction,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               halted
);

   import pachet_risc8::*;

   stare_fetch_t        state, state_next;
   logic                free;
   logic                pc_load;
   logic [ADDR_W-1:0]   pc_load_val;
   logic                pc_inc;
   logic                capture;
   logic                clear_valid;
   logic                is_halt;

   assign free = !instr_valid || instr_ready;

`ifdef RISC8_FETCH_HALT_EN
   assign is_halt = (instruction == HALT_WORD);
   assign halted  = (state == HALTED);
`else
   assign is_halt = 1'b0;
   assign halted  = 1'b0;
`endif

   numarator_pc #(
      .W         (ADDR_W),
      .RESET_VAL (RESET_PC)
   ) u_pc (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (pc_load),
      .load_val (pc_load_val),
      .inc      (pc_inc),
      .value    (address)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next state and PC / output-register controls; redirect overrides everything
   always_comb begin
      state_next  = state;
      pc_load     = 1'b0;
      pc_load_val = redirect_pc;
      pc_inc      = 1'b0;
      capture     = 1'b0;
      clear_valid = 1'b0;
      if (redirect) begin
         state_next  = RUN;
         pc_load     = 1'b1;
         pc_load_val = redirect_pc;
         clear_valid = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_next  = RUN;
                  pc_load     = 1'b1;
                  pc_load_val = RESET_PC;
               end
            end
            RUN: begin
               if (free) begin
                  if (is_halt) begin
                     state_next  = HALTED;
                     clear_valid = 1'b1;
                  end else begin
                     capture = 1'b1;
                     pc_inc  = 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // output register toward decode: capture, drain when free, hold when stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_out   <= '0;
         pc_out      <= '0;
         instr_valid <= 1'b0;
      end else if (capture) begin
         instr_out   <= instruction;
         pc_out      <= address;
         instr_valid <= 1'b1;
      end else if (clear_valid || free) begin
         instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_unitate_fetch.sv
// tb/tb_unitate_fetch.sv - directed self-checking bench for unitate_fetch
module tb_unitate_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  address;
   logic [15:0] instruction;
   logic [15:0] instr_out;
   logic [7:0]  pc_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        halted;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [15:0] PROG [0:6] = '{16'h012A, 16'h134B, 16'h256C, 16'h378D,
                                           16'h5999, 16'h49AE, 16'h6BAB};

   always #5 clk = ~clk;

   function automatic logic [15:0] mem(input logic [7:0] a);
      if (a <= 8'd6) return PROG[a];
      return 16'hFFFF;
   endfunction

   assign instruction = mem(address);

   unitate_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .address     (address),
      .instruction (instruction),
      .instr_out   (instr_out),
      .pc_out      (pc_out),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halted      (halted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [15:0] w, input logic [7:0] p);
      chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
      chk({tag, ".instr"}, 32'(instr_out), 32'(w));
      chk({tag, ".pc"}, 32'(pc_out), 32'(p));
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 8'd0;
      instr_ready = 1'b1;
      tick();
      tick();
      chk("rst.address", 32'(address), 32'd0);
      chk("rst.valid", 32'(instr_valid), 32'd0);
      chk("rst.instr", 32'(instr_out), 32'd0);
      chk("rst.pc", 32'(pc_out), 32'd0);
      chk("rst.halted", 32'(halted), 32'd0);

      rst_n = 1'b1;
      tick();
      tick();
      chk("idle.valid", 32'(instr_valid), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start.address", 32'(address), 32'd0);
      chk("start.valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk_out($sformatf("stream%0d", i), PROG[i], 8'(i));
      end
      tick();
`ifdef RISC8_FETCH_HALT_EN
      chk("halt.halted", 32'(halted), 32'd1);
      chk("halt.valid", 32'(instr_valid), 32'd0);
      chk("halt.address", 32'(address), 32'd7);
`else
      chk_out("ffff7", 16'hFFFF, 8'd7);
      chk("nohalt.halted", 32'(halted), 32'd0);
      tick();
      chk_out("ffff8", 16'hFFFF, 8'd8);
`endif

      redirect    = 1'b1;
      redirect_pc = 8'd0;
      tick();
      redirect = 1'b0;
      chk("rd0.valid", 32'(instr_valid), 32'd0);
      chk("rd0.halted", 32'(halted), 32'd0);
      tick();
      chk_out("rd0.w0", 16'h012A, 8'd0);
      tick();
      chk_out("rd0.w1", 16'h134B, 8'd1);
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("stall%0d", i), 16'h134B, 8'd1);
      end
      instr_ready = 1'b1;
      tick();
      chk_out("after_stall", 16'h256C, 8'd2);

      redirect    = 1'b1;
      redirect_pc = 8'd5;
      tick();
      redirect = 1'b0;
      chk("rd5.valid", 32'(instr_valid), 32'd0);
      chk("rd5.address", 32'(address), 32'd5);
      tick();
      chk_out("rd5.w5", 16'h49AE, 8'd5);
      tick();
      chk_out("rd5.w6", 16'h6BAB, 8'd6);
      tick();
`ifdef RISC8_FETCH_HALT_EN
      chk("halt2.halted", 32'(halted), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("halt2.start_ignored", 32'(halted), 32'd1);
      chk("halt2.valid", 32'(instr_valid), 32'd0);
      chk("halt2.address", 32'(address), 32'd7);
      redirect    = 1'b1;
      redirect_pc = 8'd3;
      tick();
      redirect = 1'b0;
      chk("rd3.halted", 32'(halted), 32'd0);
      chk("rd3.valid", 32'(instr_valid), 32'd0);
      tick();
      chk_out("rd3.w3", 16'h378D, 8'd3);
`else
      chk_out("ffff7b", 16'hFFFF, 8'd7);
      redirect    = 1'b1;
      redirect_pc = 8'd255;
      tick();
      redirect = 1'b0;
      chk("rd255.valid", 32'(instr_valid), 32'd0);
      tick();
      chk_out("wrap.255", 16'hFFFF, 8'd255);
      tick();
      chk_out("wrap.0", 16'h012A, 8'd0);
`endif

      tick();
      chk("pre_rst.valid", 32'(instr_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.valid", 32'(instr_valid), 32'd0);
      chk("arst.instr", 32'(instr_out), 32'd0);
      chk("arst.pc", 32'(pc_out), 32'd0);
      chk("arst.address", 32'(address), 32'd0);
      chk("arst.halted", 32'(halted), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_rst%0d.valid", i), 32'(instr_valid), 32'd0);
         chk($sformatf("post_rst%0d.address", i), 32'(address), 32'd0);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk_out("restart.w0", 16'h012A, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/unitate_fetch.md
# unitate_fetch

Instruction fetch stage of the RISC-8 core.
- Owns the 8-bit program counter and drives the address of the combinational instruction memory.
- Captures the returned 16-bit word into an output register and hands it to the decode stage over a valid/ready handshake.
- Supports branch/jump redirection from execute and stops fetching when it reads the halt word 16'hFFFF.

## Interface
Parameters:
- ADDR_W, 8, program counter / memory address width
- INSTR_W, 16, instruction width
- RESET_PC, 8'd0, PC value after reset and the start address used by `start`

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- start  input  1  single-cycle pulse; begins fetching at RESET_PC when in IDLE
- address  output  ADDR_W  instruction memory address, equal to the PC register (combinational from the register)
- instruction  input  INSTR_W  word returned by the instruction memory, same cycle
- instr_out  output  INSTR_W  captured instruction to decode
- pc_out  output  ADDR_W  address from which instr_out was fetched
- instr_valid  output  1  instr_out/pc_out are valid
- instr_ready  input  1  decode accepts instr_out this cycle
- redirect  input  1  branch/jump taken; load redirect_pc and flush
- redirect_pc  input  ADDR_W  redirect target
- halted  output  1  FSM is in HALTED

## Operation
- FSM states are IDLE, RUN and HALTED. Reset state is IDLE.
- Reset values: PC = RESET_PC, address = RESET_PC, instr_out = 0, pc_out = 0, instr_valid = 0, halted = 0.
- IDLE transitions:
  - `start` -> RUN with PC = RESET_PC.
  - `redirect` -> RUN with PC = redirect_pc. `redirect` has priority over `start`.
  - Otherwise stay in IDLE; no capture.
- Output register "free" = !instr_valid || instr_ready.
- RUN, capture: if free and `instruction` is not the halt word, then:
  - instr_out <= instruction, pc_out <= PC, instr_valid <= 1.
  - PC <= PC + 1, modulo 2^ADDR_W (255 -> 0).
- RUN, hold: if not free, PC and the output register are unchanged (stall).
- RUN, drain: if free and nothing is captured, instr_valid <= 0.
- RUN, halt: if free and `instruction` == 16'hFFFF:
  - Go to HALTED. PC stays at the halt address.
  - The halt word is never forwarded. instr_valid <= 0, since the register is free.
- HALTED:
  - No capture; halted = 1.
  - `redirect` -> RUN with PC = redirect_pc. `start` is ignored.
- `redirect` in any state has priority over capture and halt:
  - PC <= redirect_pc and instr_valid <= 0.
  - A handshake on the current output in the same cycle still counts as accepted by decode.
  - The word on `instruction` that cycle is discarded.
- Asynchronous reset mid-operation returns everything to the reset values immediately. Any in-flight instruction is lost.

## Timing
- `start` at cycle N: address = RESET_PC during N+1; instr_valid = 1 with word[RESET_PC] from N+2.
- Throughput is one instruction per cycle while instr_ready = 1.
- Redirect latency: redirect at cycle R -> instr_valid = 0 at R+1; word[redirect_pc] valid at R+2.
- Halt: halt word presented at cycle H -> halted = 1 from H+1.
- The handshake rule holds while instr_ready = 0: instr_out, pc_out and instr_valid stay stable until accepted or flushed by `redirect`.

## Configuration
- Macro: RISC8_FETCH_HALT_EN.
- Defined: halt-word detection as described above; halted is driven from the FSM.
- Undefined:
  - 16'hFFFF is fetched and forwarded like any other word.
  - HALTED is unreachable; halted is tied to 0.
  - PC keeps wrapping modulo 2^ADDR_W.

## Structure
- Shared package pachet_risc8 holds:
  - ADDR_W, INSTR_W and the opcode field width (4).
  - HALT_WORD = 16'hFFFF.
  - The fetch state enum stare_fetch_t {IDLE, RUN, HALTED}.
- One sub-module is natural: numarator_pc, the PC register.
  - Controls: load (value), increment and hold.
  - Wrap-around lives there.
- The FSM and the output register stay in unitate_fetch.

## Test plan
The bench memory model holds:
- 0:0x012A
- 1:0x134B
- 2:0x256C
- 3:0x378D
- 4:0x5999
- 5:0x49AE
- 6:0x6BAB
- all others 0xFFFF

Directed scenarios:
- Reset then `start`, instr_ready = 1 -> outputs 0x012A..0x6BAB with pc_out 0..6 on consecutive cycles. Then halted = 1 and instr_valid = 0; with the macro undefined, 0xFFFF streams with pc_out 7, 8, ...
- instr_ready low for 3 cycles while 0x134B (pc 1) is valid -> instr_out, pc_out and instr_valid stay stable; the next accepted word is 0x256C.
- Redirect to 5 while pc_out = 2 is being accepted -> instr_valid = 0 next cycle, then 0x49AE (pc 5) and 0x6BAB (pc 6).
- In HALTED, redirect to 3 -> halted drops and 0x378D appears two cycles later; `start` pulses in HALTED have no effect.
- Redirect to 255 with the macro undefined -> pc_out 255 then 0 with 0x012A, checking wrap-around.
- Assert rst_n low mid-stream -> all outputs take their reset values asynchronously; after release, nothing is fetched until `start`.
